// File: rtl/rr_src_arbiter_pkg.sv
// Shared sizes, state type and the requester priority search for rr_src_arbiter.
package rr_src_arbiter_pkg;

   localparam int NREQ   = 6;
   localparam int SEL_W  = 3;
   localparam int DATA_W = 4;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef struct packed {
      logic             any;
      logic [SEL_W-1:0] idx;
   } pick_t;

   // Winner is the first set req bit searching upward from (last+1), wrapping at NREQ.
   // The search runs from the farthest candidate to the nearest so the nearest one wins.
   // Passing last = NREQ-1 turns this into a plain lowest-index-first search.
   function automatic pick_t pick_winner(input logic [NREQ-1:0] req,
                                         input logic [SEL_W-1:0] last);
      pick_t            p;
      logic [SEL_W-1:0] j;
      p = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = SEL_W'((int'(last) + k) % NREQ);
         if (req[j]) begin
            p.any = 1'b1;
            p.idx = j;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_src_arbiter_mux6x1.sv
// 6:1 operand mux; unused select codes return zero.
module mux6x1
   import rr_src_arbiter_pkg::*;
(
   input  logic [DATA_W-1:0] d0,
   input  logic [DATA_W-1:0] d1,
   input  logic [DATA_W-1:0] d2,
   input  logic [DATA_W-1:0] d3,
   input  logic [DATA_W-1:0] d4,
   input  logic [DATA_W-1:0] d5,
   input  logic [SEL_W-1:0]  s,
   output logic [DATA_W-1:0] y
);

   // Select the operand addressed by s.
   always_comb begin
      y = '0;
      case (s)
         3'd0:    y = d0;
         3'd1:    y = d1;
         3'd2:    y = d2;
         3'd3:    y = d3;
         3'd4:    y = d4;
         3'd5:    y = d5;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/rr_src_arbiter.sv
// Six-source arbiter feeding a single registered output slot with valid/ready backpressure.
//
// state | meaning
// ------+------------------------------------------------------------
// EMPTY | output slot holds no data; a request is granted immediately
// FULL  | dout holds unconsumed data; new grant only when dout_ready
module rr_src_arbiter
   import rr_src_arbiter_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  req,
   input  logic [3:0]  data_a,
   input  logic [3:0]  data_b,
   input  logic [3:0]  data_c,
   input  logic [3:0]  data_d,
   input  logic [3:0]  data_e,
   input  logic [3:0]  data_f,
   output logic [5:0]  gnt,
   output logic [2:0]  sel,
   output logic [3:0]  dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic        busy
);

   state_t              state;
   logic [SEL_W-1:0]    last;
   pick_t               pick;
   logic                slot_free;
   logic                take;
   logic [DATA_W-1:0]   mux_y;

   // Priority search; fixed-priority mode pins the pointer so index 0 is searched first.
   always_comb begin
      pick = pick_winner(req, (FIXED_PRIO != 0) ? SEL_W'(NREQ - 1) : last);
   end

   assign slot_free = (state == EMPTY) || dout_ready;
   assign take      = rst_n && slot_free && pick.any;

   // One-hot accept for the winner whenever the slot can take new data.
   always_comb begin
      gnt = '0;
      if (take) gnt[pick.idx] = 1'b1;
   end

   mux6x1 u_mux (
      .d0 (data_a),
      .d1 (data_b),
      .d2 (data_c),
      .d3 (data_d),
      .d4 (data_e),
      .d5 (data_f),
      .s  (pick.idx),
      .y  (mux_y)
   );

   // Slot FSM: load the winner when free, drain to EMPTY when consumed with nothing new.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= EMPTY;
         dout  <= '0;
         sel   <= '0;
         last  <= SEL_W'(NREQ - 1);
      end else if (slot_free) begin
         if (take) begin
            state <= FULL;
            dout  <= mux_y;
            sel   <= pick.idx;
            last  <= pick.idx;
         end else begin
            state <= EMPTY;
         end
      end
   end

   assign dout_valid = (state == FULL);
   assign busy       = dout_valid || (|req);

endmodule

// File: doc/rr_src_arbiter.md
RR_SRC_ARBITER -- requirements
Module: rr_src_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 1 = fixed priority (index 0 highest), 0 = round-robin.
REQ-002 Port: clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 Port: rst_n, input, 1, reset; synchronous and active-low.
REQ-004 Port: req, input, 6, per-requester valid; bit i means data_i is offered.
REQ-005 Port: data_a..data_f, input, 4 each, requester operands; index 0..5 in that order.
REQ-006 Port: gnt, output, 6, one-hot accept; gnt[i]=1 means data_i is consumed this cycle.
REQ-007 Port: sel, output, 3, mux select; value = index of the current or last granted requester.
REQ-008 Port: dout, output, 4, registered selected operand.
REQ-009 Port: dout_valid, output, 1, dout holds unconsumed data.
REQ-010 Port: dout_ready, input, 1, downstream accepts dout when dout_valid=1.
REQ-011 Port: busy, output, 1, equals dout_valid OR (|req).

Function
REQ-012 States SHALL be EMPTY (dout_valid=0) and FULL (dout_valid=1).
- Slot free = EMPTY, or FULL with dout_ready=1.
REQ-013 When the slot is free and |req=1, exactly one gnt bit SHALL assert combinationally in that cycle.
- The next edge loads dout <= data of the winner, sets sel to the winner, and enters FULL.
REQ-014 When the slot is free and req=0, gnt SHALL be 0.
- FULL with dout_ready=1 goes to EMPTY.
- EMPTY stays EMPTY.
REQ-015 In FULL with dout_ready=0, gnt SHALL be 0 and dout/sel/dout_valid SHALL hold (backpressure).
REQ-016 Round-robin winner SHALL be the first requester with req set, searching from (last+1) mod 6 upward; index 5 wraps to 0.
REQ-017 Pointer "last" SHALL update only on a grant.
REQ-018 With FIXED_PRIO=1, the winner SHALL be the lowest-indexed requester with req set, and the pointer SHALL be ignored.
REQ-019 Latency: req accepted in cycle N -> dout_valid=1 with that data in cycle N+1.
- Throughput is one transfer per cycle while dout_ready=1.
REQ-020 Simultaneous consume-and-grant (FULL, dout_ready=1, |req=1) SHALL reload dout and stay FULL.
- No bubble.
REQ-021 sel SHALL never take values 6 or 7.
REQ-022 sel SHALL hold its last value while no grant occurs.

Reset
REQ-023 When rst_n=0 at a clock edge, the next state SHALL be: EMPTY, dout_valid=0, dout=0, sel=0, last=5.
- last=5 makes requester 0 win first.
REQ-024 During reset, gnt SHALL be 0 regardless of req.
REQ-025 Data held in dout when reset is asserted mid-transfer SHALL be discarded without a handshake.

Structure
REQ-026 Shared package SHALL hold:
- NREQ=6, SEL_W=3, DATA_W=4
- enum state type {EMPTY, FULL}
REQ-027 The data path SHALL instantiate the existing 6:1 operand mux sub-module mux6x1.
- It is driven by the combinational winner index.
- Its output is registered into dout.
- No duplicate mux logic.
REQ-028 The priority search SHALL be a single combinational function.
- Input: req plus pointer.
- Output: winner index and any-request flag.

Verification
REQ-029 Reset then req=6'b111111, dout_ready=1 for 7 cycles -> gnt sequence 0,1,2,3,4,5,0 (one-hot); dout follows data_a..f,data_a one cycle later.
REQ-030 req=6'b100001, last=5 after reset -> gnt[0] first, then gnt[5], then gnt[0]; sel = 0,5,0.
REQ-031 FULL with dout=4'hA, dout_ready=0 for 3 cycles, req=6'b000010 -> gnt=0, dout=4'hA, sel stable; on dout_ready=1, gnt[1] fires the same cycle and dout=data_b the next cycle.
REQ-032 FIXED_PRIO=1, req=6'b101100 held with dout_ready=1 -> gnt[2] every cycle; no rotation.
REQ-033 rst_n=0 asserted for one cycle while FULL -> next cycle dout_valid=0, sel=0, gnt=0; first grant after release goes to the lowest active index.
REQ-034 Random req/dout_ready for 10k cycles -> gnt always one-hot-or-zero, sel<=5, no lost or duplicated transfer (scoreboard).
